// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the lap stopwatch: FSM state encoding,
// BCD digit width, per-digit limits and active-low 7-segment patterns.
package stopwatch_pkg;

    typedef enum logic [2:0] {
        ST_CLR = 3'd0,
        ST_RUN = 3'd1,
        ST_PSE = 3'd2,
        ST_LAP = 3'd3,
        ST_LPS = 3'd4
    } state_t;

    localparam int DW = 4;

    // Segment order {g,f,e,d,c,b,a}, a lit segment is 0.
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Digit 3 is the tens-of-seconds digit (0-5); every other digit is 0-9.
    function automatic logic [DW-1:0] digit_max(input int idx);
        return (idx == 3) ? 4'd5 : 4'd9;
    endfunction

endpackage

// File: rtl/bcd2seg.sv
// One BCD digit to an active-low 7-segment pattern; codes above 9 blank.
module bcd2seg
    import stopwatch_pkg::*;
(
    input  logic [DW-1:0] bcd_i,
    output logic [6:0]    seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/stopwatch_lap.sv
// Lap stopwatch: BCD hundredths/seconds/minutes counter with split hold,
// wrap-or-saturate at full scale. STOPWATCH_LAP_SEG7_EN adds the seg output.
//
//   state | meaning
//   CLR   | cleared, counter zero, waiting for run
//   RUN   | counting, live display
//   PSE   | paused, live display
//   LAP   | counting, display frozen on snapshot
//   LPS   | paused, display frozen on snapshot
module stopwatch_lap
    import stopwatch_pkg::*;
#(
    parameter int CPT  = 240000,
    parameter int MDN  = 2,
    parameter int WRAP = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    b_run,
    input  logic                    b_clr,
    input  logic                    b_lap,
    output logic [4*(4+MDN)-1:0]    time_bcd,
    output logic                    s_run,
    output logic                    s_hld,
    output logic                    s_ovf
`ifdef STOPWATCH_LAP_SEG7_EN
    ,
    output logic [7*(4+MDN)-1:0]    seg
`endif
);

    localparam int ND = 4 + MDN;
    localparam int PW = $clog2(CPT);
    localparam logic [PW-1:0] PMAX = PW'(CPT - 1);

    state_t           state_q;
    logic             run_q, clr_q, lap_q;
    logic [PW-1:0]    presc_q;
    logic [DW*ND-1:0] cnt_q, snap_q, cnt_inc;
    logic             ev_run, ev_clr, ev_lap;
    logic             sel_run, sel_clr, sel_lap;
    logic             counting, tick, full, sat, carry;

    always_comb begin
        ev_run   = b_run & ~run_q;
        ev_clr   = b_clr & ~clr_q;
        ev_lap   = b_lap & ~lap_q;
        // Only the highest-priority event is ever considered.
        sel_clr  = ev_clr;
        sel_run  = ev_run & ~ev_clr;
        sel_lap  = ev_lap & ~ev_run & ~ev_clr;
        counting = (state_q == ST_RUN) || (state_q == ST_LAP);
        tick     = counting && (presc_q == PMAX);
        full     = 1'b1;
        carry    = 1'b1;
        cnt_inc  = cnt_q;
        for (int i = 0; i < ND; i++) begin
            if (cnt_q[DW*i +: DW] != digit_max(i)) full = 1'b0;
            if (carry) begin
                if (cnt_q[DW*i +: DW] == digit_max(i)) begin
                    cnt_inc[DW*i +: DW] = '0;
                end else begin
                    cnt_inc[DW*i +: DW] = cnt_q[DW*i +: DW] + 1'b1;
                    carry = 1'b0;
                end
            end
        end
        sat = tick && full && (WRAP == 0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_CLR;
            run_q    <= 1'b0;
            clr_q    <= 1'b0;
            lap_q    <= 1'b0;
            presc_q  <= '0;
            cnt_q    <= '0;
            snap_q   <= '0;
            time_bcd <= '0;
            s_run    <= 1'b0;
            s_hld    <= 1'b0;
            s_ovf    <= 1'b0;
        end else begin
            run_q    <= b_run;
            clr_q    <= b_clr;
            lap_q    <= b_lap;
            time_bcd <= ((state_q == ST_LAP) || (state_q == ST_LPS)) ? snap_q : cnt_q;
            s_run    <= counting;
            s_hld    <= (state_q == ST_LAP) || (state_q == ST_LPS);

            if (counting) presc_q <= tick ? '0 : presc_q + 1'b1;
            if (tick) begin
                if (!full) begin
                    cnt_q <= cnt_inc;
                end else begin
                    s_ovf <= 1'b1;
                    if (WRAP != 0) cnt_q <= '0;
                end
            end

            case (state_q)
                ST_CLR: if (sel_run) state_q <= ST_RUN;
                ST_RUN: begin
                    if (sel_lap) begin
                        snap_q  <= cnt_q;
                        state_q <= sat ? ST_LPS : ST_LAP;
                    end else if (sel_run || sat) begin
                        state_q <= ST_PSE;
                    end
                end
                ST_LAP: begin
                    if (sel_lap)             state_q <= sat ? ST_PSE : ST_RUN;
                    else if (sel_run || sat) state_q <= ST_LPS;
                end
                ST_PSE: begin
                    if (sel_clr) begin
                        state_q <= ST_CLR;
                        cnt_q   <= '0;
                        presc_q <= '0;
                        snap_q  <= '0;
                        s_ovf   <= 1'b0;
                    end else if (sel_run) begin
                        state_q <= ST_RUN;
                    end
                end
                ST_LPS: begin
                    if (sel_clr) begin
                        state_q <= ST_CLR;
                        cnt_q   <= '0;
                        presc_q <= '0;
                        snap_q  <= '0;
                        s_ovf   <= 1'b0;
                    end else if (sel_run) begin
                        state_q <= ST_LAP;
                    end else if (sel_lap) begin
                        state_q <= ST_PSE;
                    end
                end
                default: state_q <= ST_CLR;
            endcase
        end
    end

`ifdef STOPWATCH_LAP_SEG7_EN
    logic [7*ND-1:0] seg_d;

    for (genvar g = 0; g < ND; g++) begin : g_dec
        bcd2seg u_dec (
            .bcd_i (time_bcd[DW*g +: DW]),
            .seg_o (seg_d[7*g +: 7])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) seg <= {ND{SEG_0}};
        else      seg <= seg_d;
    end
`endif

endmodule

// File: tb/tb_stopwatch_lap.sv
// Self-checking bench for stopwatch_lap: a wrapping and a saturating instance
// share stimulus and are compared against a tick-count reference model.
module tb_stopwatch_lap;

    localparam int CPT = 4;
    localparam int MDN = 2;
    localparam int W   = 4 * (4 + MDN);
    localparam int FS  = 599999;
    localparam int M_CLR = 0, M_RUN = 1, M_PSE = 2, M_LAP = 3, M_LPS = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic b_run = 1'b0, b_clr = 1'b0, b_lap = 1'b0;
    logic [W-1:0] t_w, t_s;
    logic r_w, h_w, o_w, r_s, h_s, o_s;
`ifdef STOPWATCH_LAP_SEG7_EN
    logic [7*(4+MDN)-1:0] seg_w, seg_s;
`endif

    int ncmp = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    stopwatch_lap #(.CPT(CPT), .MDN(MDN), .WRAP(1)) dut_w (
        .clk(clk), .rst(rst), .b_run(b_run), .b_clr(b_clr), .b_lap(b_lap),
        .time_bcd(t_w), .s_run(r_w), .s_hld(h_w), .s_ovf(o_w)
`ifdef STOPWATCH_LAP_SEG7_EN
        , .seg(seg_w)
`endif
    );

    stopwatch_lap #(.CPT(CPT), .MDN(MDN), .WRAP(0)) dut_s (
        .clk(clk), .rst(rst), .b_run(b_run), .b_clr(b_clr), .b_lap(b_lap),
        .time_bcd(t_s), .s_run(r_s), .s_hld(h_s), .s_ovf(o_s)
`ifdef STOPWATCH_LAP_SEG7_EN
        , .seg(seg_s)
`endif
    );

    // Reference model: time kept as an integer count of hundredths.
    int           m_mode[2], m_presc[2], m_ticks[2], m_snap[2];
    logic         m_ovf[2];
    logic [W-1:0] e_time[2];
    logic         e_run[2], e_hld[2];
    logic         p_run, p_clr, p_lap;

    function automatic logic [W-1:0] to_bcd(input int t);
        int cs, s, m;
        cs = t % 100;
        s  = (t / 100) % 60;
        m  = t / 6000;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(cs / 10), 4'(cs % 10)};
    endfunction

    always @(posedge clk or negedge rst) begin : model
        logic er, ec, el, held, sat, lap_sel, run_sel;
        int   old;
        if (!rst) begin
            p_run = 0; p_clr = 0; p_lap = 0;
            for (int k = 0; k < 2; k++) begin
                m_mode[k] = M_CLR; m_presc[k] = 0; m_ticks[k] = 0; m_snap[k] = 0;
                m_ovf[k] = 0; e_time[k] = '0; e_run[k] = 0; e_hld[k] = 0;
            end
        end else begin
            er = b_run && !p_run;
            ec = b_clr && !p_clr;
            el = b_lap && !p_lap;
            p_run = b_run; p_clr = b_clr; p_lap = b_lap;
            run_sel = er && !ec;
            lap_sel = el && !er && !ec;
            for (int k = 0; k < 2; k++) begin
                held      = (m_mode[k] == M_LAP) || (m_mode[k] == M_LPS);
                e_time[k] = to_bcd(held ? m_snap[k] : m_ticks[k]);
                e_run[k]  = (m_mode[k] == M_RUN) || (m_mode[k] == M_LAP);
                e_hld[k]  = held;
                old = m_ticks[k];
                sat = 0;
                if (e_run[k]) begin
                    if (m_presc[k] == CPT - 1) begin
                        m_presc[k] = 0;
                        if (m_ticks[k] == FS) begin
                            m_ovf[k] = 1;
                            if (k == 0) m_ticks[k] = 0;
                            else        sat = 1;
                        end else begin
                            m_ticks[k]++;
                        end
                    end else begin
                        m_presc[k]++;
                    end
                end
                case (m_mode[k])
                    M_CLR: if (run_sel) m_mode[k] = M_RUN;
                    M_RUN: begin
                        if (lap_sel) begin
                            m_snap[k] = old;
                            m_mode[k] = sat ? M_LPS : M_LAP;
                        end else if (run_sel || sat) m_mode[k] = M_PSE;
                    end
                    M_LAP: begin
                        if (lap_sel) m_mode[k] = sat ? M_PSE : M_RUN;
                        else if (run_sel || sat) m_mode[k] = M_LPS;
                    end
                    default: begin
                        if (ec) begin
                            m_mode[k] = M_CLR; m_ticks[k] = 0; m_presc[k] = 0;
                            m_snap[k] = 0; m_ovf[k] = 0;
                        end else if (er) begin
                            m_mode[k] = (m_mode[k] == M_PSE) ? M_RUN : M_LAP;
                        end else if (el && m_mode[k] == M_LPS) begin
                            m_mode[k] = M_PSE;
                        end
                    end
                endcase
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic press(input logic r, input logic c, input logic l);
        b_run = r; b_clr = c; b_lap = l;
        cyc(1);
        b_run = 0; b_clr = 0; b_lap = 0;
    endtask

    task automatic preload(input logic [W-1:0] v, input int t);
        dut_w.cnt_q = v;
        dut_s.cnt_q = v;
        m_ticks[0] = t;
        m_ticks[1] = t;
    endtask

    task automatic test_reset;
        @(negedge clk);
        ncmp++; if (t_w !== '0 || t_s !== '0) begin nerr++; $display("FAIL reset_time: got %h/%h want 0", t_w, t_s); end
        ncmp++; if ({r_w, h_w, o_w, r_s, h_s, o_s} !== 6'b0) begin nerr++; $display("FAIL reset_flags: got %b want 000000", {r_w, h_w, o_w, r_s, h_s, o_s}); end
        rst = 1'b1;
        cyc(3);
        ncmp++; if (t_w !== '0 || r_w !== 1'b0) begin nerr++; $display("FAIL idle_clr: time %h run %b want 0/0", t_w, r_w); end
    endtask

    task automatic test_run_lap;
        press(1, 0, 0);
        cyc(401);
        ncmp++; if (t_w !== 24'h000100) begin nerr++; $display("FAIL run_1s: time %h want 000100", t_w); end
        ncmp++; if (r_w !== 1'b1 || o_w !== 1'b0) begin nerr++; $display("FAIL run_flags: run %b ovf %b want 1/0", r_w, o_w); end
        ncmp++; if (t_w !== e_time[0]) begin nerr++; $display("FAIL run_model: time %h model %h", t_w, e_time[0]); end
        cyc(599);
        press(0, 0, 1);
        cyc(400);
        ncmp++; if (t_w !== 24'h000250 || h_w !== 1'b1) begin nerr++; $display("FAIL lap_hold: time %h hld %b want 000250/1", t_w, h_w); end
        ncmp++; if (r_w !== 1'b1) begin nerr++; $display("FAIL lap_run: run %b want 1", r_w); end
        press(0, 0, 1);
        cyc(1);
        ncmp++; if (t_w !== 24'h000350 || h_w !== 1'b0) begin nerr++; $display("FAIL lap_release: time %h hld %b want 000350/0", t_w, h_w); end
    endtask

    task automatic test_carry;
        press(1, 0, 0);
        cyc(2);
        press(0, 1, 0);
        preload(24'h005999, 5999);
        press(1, 0, 0);
        cyc(4);
        ncmp++; if (t_w !== 24'h005999) begin nerr++; $display("FAIL pre_tick: time %h want 005999", t_w); end
        cyc(1);
        ncmp++; if (t_w !== 24'h010000 || t_s !== 24'h010000) begin nerr++; $display("FAIL carry_min: time %h/%h want 010000", t_w, t_s); end
        press(1, 0, 0);
        cyc(2);
        press(0, 1, 0);
        preload(24'h995999, FS);
        press(1, 0, 0);
        cyc(5);
        ncmp++; if (t_w !== '0 || o_w !== 1'b1 || r_w !== 1'b1) begin nerr++; $display("FAIL wrap: time %h ovf %b run %b want 000000/1/1", t_w, o_w, r_w); end
        ncmp++; if (t_s !== 24'h995999 || o_s !== 1'b1 || r_s !== 1'b0) begin nerr++; $display("FAIL saturate: time %h ovf %b run %b want 995999/1/0", t_s, o_s, r_s); end
    endtask

    task automatic test_clr_priority;
        press(1, 0, 0);
        cyc(6);
        press(1, 1, 0);
        cyc(1);
        ncmp++; if (t_w !== '0 || r_w !== 1'b0 || o_w !== 1'b0) begin nerr++; $display("FAIL clr_prio_w: time %h run %b ovf %b want 0/0/0", t_w, r_w, o_w); end
        ncmp++; if (t_s !== '0 || r_s !== 1'b0 || o_s !== 1'b0) begin nerr++; $display("FAIL clr_prio_s: time %h run %b ovf %b want 0/0/0", t_s, r_s, o_s); end
        cyc(6);
        ncmp++; if (t_w !== '0 || r_w !== 1'b0) begin nerr++; $display("FAIL clr_run_ignored: time %h run %b want 0/0", t_w, r_w); end
    endtask

    task automatic test_reset_midlap;
        press(1, 0, 0);
        cyc(10);
        press(0, 0, 1);
        cyc(7);
        rst = 1'b0;
        #1;
        ncmp++; if (t_w !== '0 || t_s !== '0 || {r_w, h_w, o_w, r_s, h_s, o_s} !== 6'b0) begin nerr++; $display("FAIL async_reset: time %h flags %b want 0", t_w, {r_w, h_w, o_w, r_s, h_s, o_s}); end
        @(negedge clk);
        rst = 1'b1;
        cyc(3);
        press(1, 0, 0);
        cyc(4);
        ncmp++; if (t_w !== '0) begin nerr++; $display("FAIL restart_early: time %h want 000000", t_w); end
        cyc(1);
        ncmp++; if (t_w !== 24'h000001 || r_w !== 1'b1) begin nerr++; $display("FAIL restart_tick: time %h run %b want 000001/1", t_w, r_w); end
    endtask

    task automatic test_random;
        for (int i = 0; i < 3000; i++) begin
            ncmp++; if (t_w !== e_time[0]) begin nerr++; $display("FAIL rnd_time_w @%0d: got %h want %h", i, t_w, e_time[0]); end
            ncmp++; if (t_s !== e_time[1]) begin nerr++; $display("FAIL rnd_time_s @%0d: got %h want %h", i, t_s, e_time[1]); end
            ncmp++; if ({r_w, h_w, o_w} !== {e_run[0], e_hld[0], m_ovf[0]}) begin nerr++; $display("FAIL rnd_flags_w @%0d: got %b want %b", i, {r_w, h_w, o_w}, {e_run[0], e_hld[0], m_ovf[0]}); end
            ncmp++; if ({r_s, h_s, o_s} !== {e_run[1], e_hld[1], m_ovf[1]}) begin nerr++; $display("FAIL rnd_flags_s @%0d: got %b want %b", i, {r_s, h_s, o_s}, {e_run[1], e_hld[1], m_ovf[1]}); end
            b_run = ($urandom_range(0, 15) == 0);
            b_clr = ($urandom_range(0, 11) == 0);
            b_lap = ($urandom_range(0, 9) == 0);
            cyc(1);
        end
        b_run = 0; b_clr = 0; b_lap = 0;
    endtask

`ifdef STOPWATCH_LAP_SEG7_EN
    task automatic test_seg;
        rst = 1'b0;
        #1;
        ncmp++; if (seg_w !== {6{7'b1000000}}) begin nerr++; $display("FAIL seg_reset: got %h", seg_w); end
        @(negedge clk);
        rst = 1'b1;
        cyc(2);
        press(1, 0, 0);
        cyc(3521);
        press(1, 0, 0);
        cyc(3);
        ncmp++; if (t_w !== 24'h000880) begin nerr++; $display("FAIL seg_time: time %h want 000880", t_w); end
        ncmp++; if (seg_w[20:0] !== {7'b0000000, 7'b0000000, 7'b1000000}) begin nerr++; $display("FAIL seg_digits: got %b want 000000000000001000000", seg_w[20:0]); end
    endtask
`endif

    initial begin
        test_reset();
        test_run_lap();
        test_carry();
        test_clr_priority();
        test_reset_midlap();
        test_random();
`ifdef STOPWATCH_LAP_SEG7_EN
        test_seg();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
